// File: rtl/food_pkg.sv
// food_pkg: shared constants and types for the food placer.
//   - Default geometry of the 640x480 active area in sync-referenced
//     coordinates, and the placement window derived from it.
//   - Default LFSR feedback mask and seed.
//   - FSM state encoding.
package food_pkg;

   localparam int COORD_W_DEF   = 10;
   localparam int X_MIN_DEF     = 144;
   localparam int X_MAX_DEF     = 783;
   localparam int Y_MIN_DEF     = 35;
   localparam int Y_MAX_DEF     = 514;
   localparam int MARGIN_DEF    = 6;
   localparam int GRID_LOG2_DEF = 3;
   localparam int LFSR_W_DEF    = 32;
   localparam int MAX_TRIES_DEF = 64;

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0] TAPS_DEF = 32'h80200003;
   localparam logic [31:0] SEED_DEF = 32'h1ACEB00C;

   // Inclusive placement window for the default geometry
   localparam int X_LO = X_MIN_DEF + MARGIN_DEF;
   localparam int X_HI = X_MAX_DEF - MARGIN_DEF;
   localparam int Y_LO = Y_MIN_DEF + MARGIN_DEF;
   localparam int Y_HI = Y_MAX_DEF - MARGIN_DEF;
   localparam logic [COORD_W_DEF-1:0] GRID_MASK =
      ~COORD_W_DEF'((1 << GRID_LOG2_DEF) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAW  = 2'd1,
      QUERY = 2'd2
   } state_t;

endpackage

// File: rtl/food_placer_if.sv
// food_placer_if: occupancy query/response channel between the food placer
// (master: asks "is (occ_x, occ_y) covered by the snake?") and the snake
// body store (slave: answers with occ_resp_valid/occ_hit).
//   occ_query_valid  master->slave  query pending, coordinates stable
//   occ_x, occ_y     master->slave  queried cell
//   occ_resp_valid   slave->master  answer valid this cycle
//   occ_hit          slave->master  cell occupied, qualified by occ_resp_valid
interface food_placer_if #(
   parameter int COORD_W = 10
);
   logic               occ_query_valid;
   logic [COORD_W-1:0] occ_x;
   logic [COORD_W-1:0] occ_y;
   logic               occ_resp_valid;
   logic               occ_hit;

   modport master (
      output occ_query_valid, occ_x, occ_y,
      input  occ_resp_valid, occ_hit
   );

   modport slave (
      input  occ_query_valid, occ_x, occ_y,
      output occ_resp_valid, occ_hit
   );
endinterface

// File: rtl/lfsr_galois.sv
// lfsr_galois: free-running right-shift Galois LFSR, shared by the game's
// random sources.
//   clk, rst_n  clock, async active-low reset (state <= SEED)
//   load        replace this cycle's advance with load_val
//   load_val    new state; zero is swapped for SEED so the register can
//               never lock up in the all-zero state
//   state       current LFSR contents
module lfsr_galois #(
   parameter int                LFSR_W = 32,
   parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
   parameter logic [LFSR_W-1:0] SEED   = 32'h1ACEB00C
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   always_comb begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
      if (load) state_d = (load_val == '0) ? SEED : load_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SEED;
      else        state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/food_placer.sv
// food_placer: picks a random grid-aligned food position inside the
// playfield window that is not covered by the snake.
//   clk, rst_n        clock, async active-low reset
//   spawn_req         one-cycle request (ignored while busy)
//   seed_load/val     reseed the LFSR (zero -> SEED)
//   occ               occupancy query channel (master side)
//   food_x/y/valid    published food position, valid is a level
//   busy              search in progress
//   spawn_fail        one-cycle pulse when MAX_TRIES draws are used up
module food_placer
   import food_pkg::*;
#(
   parameter int                COORD_W   = COORD_W_DEF,
   parameter int                X_MIN     = X_MIN_DEF,
   parameter int                X_MAX     = X_MAX_DEF,
   parameter int                Y_MIN     = Y_MIN_DEF,
   parameter int                Y_MAX     = Y_MAX_DEF,
   parameter int                MARGIN    = MARGIN_DEF,
   parameter int                GRID_LOG2 = GRID_LOG2_DEF,
   parameter int                LFSR_W    = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] TAPS      = TAPS_DEF,
   parameter logic [LFSR_W-1:0] SEED      = SEED_DEF,
   parameter int                MAX_TRIES = MAX_TRIES_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                spawn_req,
   input  logic                seed_load,
   input  logic [LFSR_W-1:0]   seed_val,
   food_placer_if.master       occ,
   output logic [COORD_W-1:0]  food_x,
   output logic [COORD_W-1:0]  food_y,
   output logic                food_valid,
   output logic                busy,
   output logic                spawn_fail
);

   localparam int TW = $clog2(MAX_TRIES + 1);

   // One extra bit so X_MAX+MARGIN style bounds never wrap
   localparam logic [COORD_W:0]   WX_LO = (COORD_W+1)'(X_MIN + MARGIN);
   localparam logic [COORD_W:0]   WX_HI = (COORD_W+1)'(X_MAX - MARGIN);
   localparam logic [COORD_W:0]   WY_LO = (COORD_W+1)'(Y_MIN + MARGIN);
   localparam logic [COORD_W:0]   WY_HI = (COORD_W+1)'(Y_MAX - MARGIN);
   localparam logic [COORD_W-1:0] GMASK = ~COORD_W'((1 << GRID_LOG2) - 1);

   state_t             state_q, state_d;
   logic [TW-1:0]      tries_q, tries_d, tries_inc;
   logic [COORD_W-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
   logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
   logic               food_valid_q, food_valid_d;
   logic [LFSR_W-1:0]  rnd;
   logic [COORD_W-1:0] cx, cy;
   logic               in_range, give_up;

   lfsr_galois #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (seed_val),
      .state    (rnd)
   );

   generate
      if (LFSR_W > 2*COORD_W) begin : g_spare
         logic unused_hi;
         assign unused_hi = ^rnd[LFSR_W-1:2*COORD_W];
      end
   endgenerate

   assign cx       = rnd[COORD_W-1:0] & GMASK;
   assign cy       = rnd[2*COORD_W-1:COORD_W] & GMASK;
   assign in_range = ({1'b0, cx} >= WX_LO) && ({1'b0, cx} <= WX_HI) &&
                     ({1'b0, cy} >= WY_LO) && ({1'b0, cy} <= WY_HI);

   // Saturating count; give_up fires on the attempt that reaches MAX_TRIES
   assign tries_inc = (tries_q == TW'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;
   assign give_up   = (tries_inc == TW'(MAX_TRIES));

   always_comb begin
      state_d      = state_q;
      tries_d      = tries_q;
      occ_x_d      = occ_x_q;
      occ_y_d      = occ_y_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      spawn_fail   = 1'b0;
      case (state_q)
         IDLE: begin
            if (spawn_req) begin
               state_d      = DRAW;
               tries_d      = '0;
               food_valid_d = 1'b0;
            end
         end
         DRAW: begin
            if (in_range) begin
               occ_x_d = cx;
               occ_y_d = cy;
               state_d = QUERY;
            end else begin
               tries_d = tries_inc;
               if (give_up) begin
                  spawn_fail = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         QUERY: begin
            if (occ.occ_resp_valid) begin
               if (!occ.occ_hit) begin
                  food_x_d     = occ_x_q;
                  food_y_d     = occ_y_q;
                  food_valid_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  tries_d = tries_inc;
                  if (give_up) begin
                     spawn_fail = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     state_d = DRAW;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tries_q      <= '0;
         occ_x_q      <= '0;
         occ_y_q      <= '0;
         food_x_q     <= '0;
         food_y_q     <= '0;
         food_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tries_q      <= tries_d;
         occ_x_q      <= occ_x_d;
         occ_y_q      <= occ_y_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
      end
   end

   assign occ.occ_query_valid = (state_q == QUERY);
   assign occ.occ_x           = occ_x_q;
   assign occ.occ_y           = occ_y_q;
   assign food_x              = food_x_q;
   assign food_y              = food_y_q;
   assign food_valid          = food_valid_q;
   assign busy                = (state_q != IDLE);

endmodule
